// File: rtl/sixbitcos_seq.sv
// Multi-cycle six-bit Taylor cosine: out = C0 - x^2/D2 + x^4/D4 (mod 64).
// One shared squaring multiplier; overflow is the OR of every stage flag.
module sixbitcos_seq #(
  parameter int unsigned C0 = 1,
  parameter int unsigned D2 = 2,
  parameter int unsigned D4 = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] ain,
  output logic       busy,
  output logic       done,
  output logic [5:0] out,
  output logic       overflow
);

  typedef enum logic [2:0] {StIdle, StSq, StQ4, StDiv, StSub, StAdd, StDone} state_e;

  localparam logic [5:0] C0W    = 6'(C0);
  localparam bit         D2Zero = (D2 == 0);
  localparam bit         D4Zero = (D4 == 0);
  // Substitute 1 for a zero divisor; the term itself is forced to 0 in that case.
  localparam logic [5:0] D2S    = D2Zero ? 6'd1 : 6'(D2);
  localparam logic [5:0] D4S    = D4Zero ? 6'd1 : 6'(D4);

  state_e      state_q;
  logic [5:0]  x_q, p2_q, p4_q, t1_q, t2_q, s_q, out_q;
  logic        f0_q, f1_q, f2_q, fz_q;
  logic        busy_q, done_q, ovf_q;

  logic [5:0]  mul_op;
  logic [11:0] product;
  logic        prod_ovf;
  logic [6:0]  sum;

  always_comb begin
    mul_op   = (state_q == StSq) ? x_q : p2_q;
    product  = {6'd0, mul_op} * {6'd0, mul_op};
    prod_ovf = |product[11:6];
    sum      = {1'b0, s_q} + {1'b0, t2_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      p2_q    <= '0;
      p4_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      s_q     <= '0;
      out_q   <= '0;
      f0_q    <= 1'b0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      fz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            x_q     <= ain;
            f0_q    <= 1'b0;
            f1_q    <= 1'b0;
            f2_q    <= 1'b0;
            fz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StSq;
          end else begin
            state_q <= StIdle;
          end
        end
        StSq: begin
          p2_q    <= product[5:0];
          f0_q    <= prod_ovf;
          state_q <= StQ4;
        end
        StQ4: begin
          p4_q    <= product[5:0];
          f1_q    <= f0_q | prod_ovf;
          state_q <= StDiv;
        end
        StDiv: begin
          t1_q    <= (f0_q || D2Zero) ? 6'd0 : p2_q / D2S;
          t2_q    <= (f1_q || D4Zero) ? 6'd0 : p4_q / D4S;
          fz_q    <= D2Zero | D4Zero;
          state_q <= StSub;
        end
        StSub: begin
          s_q     <= C0W - t1_q;
          f2_q    <= (t1_q > C0W);
          state_q <= StAdd;
        end
        StAdd: begin
          out_q   <= sum[5:0];
          ovf_q   <= f0_q | f1_q | f2_q | sum[6] | fz_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out      = out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sixbitcos_seq.sv
// Bench for sixbitcos_seq: table vectors plus model-driven sweep, with a
// done-triggered scoreboard and hand sequences for back-to-back, ignore and abort.
module tb_sixbitcos_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] ain = 6'd0;
  logic       busy, done, overflow;
  logic [5:0] out;

  sixbitcos_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ain(ain),
    .busy(busy), .done(done), .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] o; logic v; } exp_t;
  typedef struct { logic [5:0] a; logic [5:0] o; logic v; } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  logic [5:0] cur_out = 6'd0;
  logic       cur_ovf = 1'b0;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Direct evaluation of the series with the stage flag rules.
  function automatic void model(input logic [5:0] a, output logic [5:0] o, output logic v);
    int p2f, p2, p4f, p4, t1, t2, s, sm;
    bit f0, f1, f2, f3;
    p2f = int'(a) * int'(a);
    f0  = p2f > 63;
    p2  = p2f % 64;
    p4f = p2 * p2;
    f1  = f0 || (p4f > 63);
    p4  = p4f % 64;
    t1  = f0 ? 0 : p2 / 2;
    t2  = f1 ? 0 : p4 / 24;
    f2  = t1 > 1;
    s   = (65 - t1) % 64;
    sm  = s + t2;
    f3  = sm > 63;
    o   = 6'(sm % 64);
    v   = f0 | f1 | f2 | f3;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_out", int'(out), int'(e.o));
        check("sb_overflow", int'(overflow), int'(e.v));
      end
    end
  end

  // Called at a negedge: drive start for one edge, optionally queue the expectation.
  task automatic launch(input logic [5:0] a, input bit push);
    logic [5:0] o;
    logic v;
    start = 1'b1;
    ain   = a;
    if (push) begin
      model(a, o, v);
      sb_q.push_back('{o: o, v: v});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    ain   = ~a;
    check("busy_after_accept", int'(busy), 1);
  endtask

  // Count busy cycles until done; out/overflow must hold their old values meanwhile.
  task automatic wait_done(input logic [5:0] prev_o, input logic prev_v, input bit disturb);
    int  cnt = 0;
    bit  seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
      end else if (busy) begin
        cnt++;
        if (cnt == 1 || cnt == 5) begin
          check("hold_out", int'(out), int'(prev_o));
          check("hold_overflow", int'(overflow), int'(prev_v));
        end
        if (disturb) begin
          start = (cnt == 2);
          ain   = 6'($urandom_range(0, 63));
        end
      end
    end
    start = 1'b0;
    check("done_seen", int'(seen), 1);
    check("busy_cycles", cnt, 5);
  endtask

  task automatic run_op(input logic [5:0] a, input bit disturb);
    logic [5:0] o;
    logic v;
    launch(a, 1'b1);
    wait_done(cur_out, cur_ovf, disturb);
    model(a, o, v);
    cur_out = o;
    cur_ovf = v;
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("idle_not_busy", int'(busy), 0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{a: 6'd0,  o: 6'd1,  v: 1'b0});
    vecs.push_back('{a: 6'd2,  o: 6'd63, v: 1'b1});
    vecs.push_back('{a: 6'd3,  o: 6'd61, v: 1'b1});
    vecs.push_back('{a: 6'd1,  o: 6'd1,  v: 1'b0});
    vecs.push_back('{a: 6'd4,  o: 6'd57, v: 1'b1});
    vecs.push_back('{a: 6'd63, o: 6'd1,  v: 1'b1});

    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out", int'(out), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors: constants cross-check the model, then the DUT via the scoreboard.
    foreach (vecs[i]) begin
      logic [5:0] o;
      logic v;
      model(vecs[i].a, o, v);
      check("table_model_out", int'(o), int'(vecs[i].o));
      check("table_model_ovf", int'(v), int'(vecs[i].v));
      run_op(vecs[i].a, 1'b0);
    end

    // ain=8 then ain=1 back-to-back with start asserted during DONE.
    launch(6'd8, 1'b1);
    wait_done(cur_out, cur_ovf, 1'b0);
    launch(6'd1, 1'b1);
    wait_done(6'd1, 1'b1, 1'b0);
    cur_out = 6'd1;
    cur_ovf = 1'b0;
    @(negedge clk);

    // start and ain wiggled while busy must be ignored.
    run_op(6'd2, 1'b1);
    run_op(6'd5, 1'b1);

    // Abort in DIV: outputs clear at once and no done ever appears for it.
    launch(6'd3, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out", int'(out), 0);
    check("abort_overflow", int'(overflow), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cur_out = 6'd0;
    cur_ovf = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done_pending", sb_q.size(), 0);
    run_op(6'd5, 1'b0);

    // Model-driven sweep over random operands.
    for (int k = 0; k < 24; k++) run_op(6'($urandom_range(0, 63)), k[0]);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
